branch_cond_gen: RTL and testbench

Registered branch-condition flag generator for the 16-bit core's branch path. It accepts a branch instruction from decode, obtains the source register value, and presents one-hot `equalto`/`lt`/`gt` flags with the opcode on a valid/ready output. The register value comes from the register file, the writeback forward bus, or a wait for a pending write. Downstream, the branch-select logic turns these flags into the PC mux select for BNEZ/BEQZ/BLTZ/BGEZ (opcodes 01100/01101/01110/01111).

---
 rtl/branch_cond_gen.sv | 154 +++++++++++++++
 tb/tb_branch_cond_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_gen.sv
// rtl/branch_cond_gen.sv - registered eq/lt/gt branch flag generator with operand wait
// Operand comes from the forward bus, the register file, or a bounded wait for a pending write.
module branch_cond_gen #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              wb_pending,
    input  logic              fwd_valid,
    input  logic [REG_W-1:0]  fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              equalto,
    output logic              lt,
    output logic              gt,
    output logic [4:0]        out_opcode,
    output logic              timeout
);

    localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [REG_W-1:0]   cap_addr, cap_addr_n;
    logic [4:0]         cap_op, cap_op_n;
    logic               ov_n, eq_n, lt_n, gt_n, to_n;
    logic [4:0]         op_n;

    logic               is_branch, accept;
    logic               new_fwd, wait_fwd;
    logic               load;
    logic [DATA_W-1:0]  ld_d;
    logic [4:0]         ld_op;

    assign in_ready  = ((state == IDLE) | ((state == HOLD) & out_ready)) & ~flush;
    assign is_branch = (opcode[4:2] == 3'b011);
    assign accept    = in_valid & in_ready & is_branch;
    assign new_fwd   = fwd_valid & (fwd_addr == rs_addr);
    assign wait_fwd  = fwd_valid & (fwd_addr == cap_addr);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cap_addr_n = cap_addr;
        cap_op_n   = cap_op;
        ov_n       = out_valid;
        eq_n       = equalto;
        lt_n       = lt;
        gt_n       = gt;
        op_n       = out_opcode;
        to_n       = 1'b0;
        load       = 1'b0;
        ld_d       = rs_data;
        ld_op      = opcode;

        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            ov_n    = 1'b0;
            eq_n    = 1'b0;
            lt_n    = 1'b0;
            gt_n    = 1'b0;
        end else if (accept) begin
            if (new_fwd || !wb_pending) begin
                load = 1'b1;
                ld_d = new_fwd ? fwd_data : rs_data;
            end else begin
                state_n    = WAIT;
                cnt_n      = '0;
                cap_addr_n = rs_addr;
                cap_op_n   = opcode;
                ov_n       = 1'b0;
                eq_n       = 1'b0;
                lt_n       = 1'b0;
                gt_n       = 1'b0;
            end
        end else begin
            case (state)
                WAIT: begin
                    if (wait_fwd || !wb_pending) begin
                        load  = 1'b1;
                        ld_d  = wait_fwd ? fwd_data : rs_data;
                        ld_op = cap_op;
                    end else if (cnt == CNT_LAST) begin
                        to_n    = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Consumer took the flags and nothing new arrived: drop back to idle.
                    if (out_ready) begin
                        state_n = IDLE;
                        ov_n    = 1'b0;
                        eq_n    = 1'b0;
                        lt_n    = 1'b0;
                        gt_n    = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (load) begin
            state_n = HOLD;
            ov_n    = 1'b1;
            eq_n    = (ld_d == '0);
            lt_n    = ld_d[DATA_W-1];
            gt_n    = (ld_d != '0) & ~ld_d[DATA_W-1];
            op_n    = ld_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_addr   <= '0;
            cap_op     <= '0;
            out_valid  <= 1'b0;
            equalto    <= 1'b0;
            lt         <= 1'b0;
            gt         <= 1'b0;
            out_opcode <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cap_addr   <= cap_addr_n;
            cap_op     <= cap_op_n;
            out_valid  <= ov_n;
            equalto    <= eq_n;
            lt         <= lt_n;
            gt         <= gt_n;
            out_opcode <= op_n;
            timeout    <= to_n;
        end
    end

endmodule

// File: tb/tb_branch_cond_gen.sv
// tb/tb_branch_cond_gen.sv - scoreboard bench for branch_cond_gen directed vectors
module tb_branch_cond_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [2:0]  rs_addr;
    logic [15:0] rs_data;
    logic        wb_pending;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        equalto, lt, gt;
    logic [4:0]  out_opcode;
    logic        timeout;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    branch_cond_gen #(.DATA_W(16), .REG_W(3), .WAIT_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs_addr(rs_addr), .rs_data(rs_data),
        .wb_pending(wb_pending), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .equalto(equalto), .lt(lt), .gt(gt),
        .out_opcode(out_opcode), .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer on the output handshake is matched against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got op=%b e/l/g=%b%b%b expected none", out_opcode, equalto, lt, gt);
            end else begin
                chk("out_flags", {out_opcode, equalto, lt, gt}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] a,
                         input logic [15:0] d, input logic p);
        in_valid = v; opcode = op; rs_addr = a; rs_data = d; wb_pending = p;
    endtask

    task automatic fwd(input logic v, input logic [2:0] a, input logic [15:0] d);
        fwd_valid = v; fwd_addr = a; fwd_data = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        fwd(1'b0, 3'd0, 16'h0000);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {out_valid, equalto, lt, gt, timeout, out_opcode}, 32'd0);
        chk("reset_in_ready", in_ready, 1);

        // BEQZ with zero operand: one-cycle latency, equalto.
        tick();
        drive(1'b1, 5'b01101, 3'd1, 16'h0000, 1'b0);
        exp_q.push_back({5'b01101, 3'b100});
        tick();
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("beqz_latency", out_valid, 1);

        // Back-to-back BLTZ then BGEZ.
        tick();
        drive(1'b1, 5'b01110, 3'd2, 16'h8000, 1'b0);
        exp_q.push_back({5'b01110, 3'b010});
        tick();
        drive(1'b1, 5'b01111, 3'd3, 16'h7FFF, 1'b0);
        exp_q.push_back({5'b01111, 3'b001});
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("b2b_second_valid", out_valid, 1);

        // BNEZ waits; mismatched forward ignored; matching forward resolves.
        tick();
        drive(1'b1, 5'b01100, 3'd3, 16'h0000, 1'b1);
        exp_q.push_back({5'b01100, 3'b001});
        tick();
        drive(1'b0, 5'b00000, 3'd3, 16'h0000, 1'b1);
        fwd(1'b1, 3'd5, 16'h0000);
        @(negedge clk);
        chk("wait0_no_out", out_valid, 0);
        chk("wait_in_ready", in_ready, 0);
        tick();
        fwd(1'b0, 3'd0, 16'h0000);
        @(negedge clk);
        chk("wait1_no_out", out_valid, 0);
        tick();
        fwd(1'b1, 3'd3, 16'h0005);
        @(negedge clk);
        chk("wait2_no_out", out_valid, 0);
        tick();
        fwd(1'b0, 3'd0, 16'h0000);
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("wait_resolved", {out_valid, gt}, 2'b11);

        // Forward beats rs_data; then stall in HOLD for 4 cycles.
        tick();
        out_ready = 1'b0;
        drive(1'b1, 5'b01101, 3'd2, 16'h0000, 1'b0);
        fwd(1'b1, 3'd2, 16'hFFFE);
        exp_q.push_back({5'b01101, 3'b010});
        tick();
        fwd(1'b0, 3'd0, 16'h0000);
        drive(1'b1, 5'b01100, 3'd4, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, equalto, lt, gt, out_opcode}, {4'b1010, 5'b01101});
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        exp_q.push_back({5'b01100, 3'b001});
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("release_out", {out_valid, out_opcode}, {1'b1, 5'b01100});

        // Unresolved wait: timeout exactly WAIT_LIMIT cycles after entry.
        tick();
        drive(1'b1, 5'b01100, 3'd4, 16'h0000, 1'b1);
        tick();
        drive(1'b0, 5'b00000, 3'd4, 16'h0000, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("timeout_early", {timeout, out_valid}, 2'b00);
            tick();
        end
        @(negedge clk);
        chk("timeout_pulse", {timeout, out_valid, in_ready}, 3'b101);
        tick();
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("timeout_one_cycle", {timeout, out_valid}, 2'b00);

        // Flush in HOLD with a simultaneous branch offered.
        tick();
        out_ready = 1'b0;
        drive(1'b1, 5'b01111, 3'd1, 16'h0010, 1'b0);
        tick();
        drive(1'b1, 5'b01101, 3'd1, 16'h0000, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_valid", {out_valid, gt}, 2'b11);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_flush", {out_valid, equalto, lt, gt, timeout}, 5'd0);
            tick();
        end

        // Non-branch opcode is accepted and dropped.
        drive(1'b1, 5'b00011, 3'd1, 16'h0000, 1'b0);
        @(negedge clk);
        chk("nonbranch_ready", in_ready, 1);
        tick();
        drive(1'b0, 5'b00000, 3'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("nonbranch_no_out", {out_valid, in_ready}, 2'b01);
        tick(); tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
